// File: rtl/inst_fetch_if.sv
`timescale 1ns/1ps
// Instruction-fetch bus stage: issues PC-register addresses on the SRAM-like bus and keeps in-order fetches in a small queue.
// Optional macro IFETCH_BYPASS_EN lets a head-entry response load IF/ID directly, saving one cycle.
module inst_fetch_if #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_vaddr_i,
  input  logic [31:0]       excepttype_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic              pc_read_ready_o,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic [31:0]       if_excepttype_o
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0]          entry_pc   [MAX_OUTSTANDING];
  logic [31:0]                entry_exc  [MAX_OUTSTANDING];
  logic [DATA_W-1:0]          entry_data [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] entry_has_data;
  logic [MAX_OUTSTANDING-1:0] entry_discard;
  logic [MAX_OUTSTANDING-1:0] entry_live;
  logic [PW-1:0]              push_ptr;
  logic [PW-1:0]              pop_ptr;
  logic [PW-1:0]              resp_ptr;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_next;
  logic full;
  logic exc_fetch;
  logic push;
  logic resp_valid;
  logic resp_fire;
  logic head_has_data;
  logic head_discard;
  logic pop_drop;
  logic pop_load;
  logic bypass;
  logic pop;

  // Slot gi is occupied when its distance from the head is below count.
  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_live
      logic [PW-1:0] offset;
      assign offset         = PW'(gi) - pop_ptr;
      assign entry_live[gi] = CW'(offset) < count;
    end
  endgenerate

  // Response target: oldest occupied entry still waiting for its bus data.
  always_comb begin
    resp_valid = 1'b0;
    resp_ptr   = pop_ptr;
    for (int k = MAX_OUTSTANDING - 1; k >= 0; k--) begin
      if (CW'(k) < count && !entry_has_data[pop_ptr + PW'(k)]) begin
        resp_valid = 1'b1;
        resp_ptr   = pop_ptr + PW'(k);
      end
    end
  end

  assign full            = (count == CW'(MAX_OUTSTANDING));
  assign exc_fetch       = (excepttype_i != 32'h0);
  assign inst_req_o      = !full && !exc_fetch;
  assign inst_addr_o     = inst_vaddr_i;
  assign push            = !full && (exc_fetch || inst_addr_ok_i);
  assign pc_read_ready_o = push;
  assign resp_fire       = inst_data_ok_i && resp_valid;
  assign head_has_data   = (count != '0) && entry_has_data[pop_ptr];
  assign head_discard    = entry_discard[pop_ptr];
  assign pop_drop        = head_has_data && (head_discard || flush_i);
  assign pop_load        = head_has_data && !head_discard && !flush_i && !stall_i;
`ifdef IFETCH_BYPASS_EN
  assign bypass = resp_fire && (resp_ptr == pop_ptr) && !head_discard && !stall_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif
  assign pop        = pop_drop || pop_load || bypass;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_ptr       <= '0;
      pop_ptr        <= '0;
      count          <= '0;
      entry_has_data <= '0;
      entry_discard  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        entry_pc[i]   <= '0;
        entry_exc[i]  <= '0;
        entry_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (push && push_ptr == PW'(i)) begin
          entry_pc[i]       <= inst_vaddr_i;
          entry_exc[i]      <= excepttype_i;
          entry_data[i]     <= '0;
          entry_has_data[i] <= exc_fetch;
          entry_discard[i]  <= 1'b0;
        end else begin
          if (resp_fire && resp_ptr == PW'(i)) begin
            entry_data[i]     <= inst_rdata_i;
            entry_has_data[i] <= 1'b1;
          end
          // Flushed entries stay queued so their bus responses are still absorbed.
          if (flush_i && entry_live[i]) entry_discard[i] <= 1'b1;
        end
      end
      if (push) push_ptr <= push_ptr + PW'(1);
      if (pop)  pop_ptr  <= pop_ptr + PW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid_o      <= 1'b0;
      if_pc_o         <= '0;
      if_inst_o       <= '0;
      if_excepttype_o <= '0;
    end else if (bypass) begin
      if_valid_o      <= 1'b1;
      if_pc_o         <= entry_pc[pop_ptr];
      if_inst_o       <= inst_rdata_i;
      if_excepttype_o <= entry_exc[pop_ptr];
    end else if (pop_load) begin
      if_valid_o      <= 1'b1;
      if_pc_o         <= entry_pc[pop_ptr];
      if_inst_o       <= entry_data[pop_ptr];
      if_excepttype_o <= entry_exc[pop_ptr];
    end else if (flush_i || !stall_i) begin
      if_valid_o <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && inst_data_ok_i && !resp_valid)
      $display("inst_fetch_if error: data_ok with no fetch awaiting data at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_inst_fetch_if.sv
`timescale 1ns/1ps
// Randomized bench for inst_fetch_if: PC-register and bus models drive the DUT, a queue-based
// reference predicts deliveries into a scoreboard that a negedge monitor checks.
module tb_inst_fetch_if;
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_vaddr_i = '0;
  logic [31:0] excepttype_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        pc_read_ready_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [31:0] if_excepttype_o;

  always #5 clk = ~clk;

  inst_fetch_if #(.MAX_OUTSTANDING(MAXO), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_vaddr_i(inst_vaddr_i), .excepttype_i(excepttype_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i), .inst_rdata_i(inst_rdata_i),
    .pc_read_ready_o(pc_read_ready_o), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .if_excepttype_o(if_excepttype_o)
  );

  typedef struct { logic [31:0] pc; logic [31:0] exc; logic [31:0] data; bit has_data; bit discard; } ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] exc; } out_t;
  typedef struct { logic [31:0] addr; int cyc; } bus_t;

  ent_t mq[$];     // fetches accepted but not yet handed to IF/ID
  out_t sb[$];     // expected IF/ID deliveries
  bus_t bq[$];     // bus requests awaiting data_ok
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   exp_valid = 0;
  bit   prev_stall = 0;
  out_t held = '{32'h0, 32'h0, 32'h0};
  logic [31:0] pc_cur = 32'hbfc00000;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h24080001;
    if (a == 32'hbfc00004) return 32'h24090002;
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  // One clock: check combinational outputs, then advance the reference at the edge.
  task automatic cycle();
    bit   m_req, m_push, m_byp, m_pop, m_deliv, head;
    int   tgt;
    out_t o;
    m_req  = (mq.size() < MAXO) && (excepttype_i == 0);
    m_push = (mq.size() < MAXO) && ((excepttype_i != 0) || inst_addr_ok_i);
    #1;
    chk("inst_req", 32'(inst_req_o), 32'(m_req));
    chk("pc_read_ready", 32'(pc_read_ready_o), 32'(m_push));
    chk("inst_addr", inst_addr_o, inst_vaddr_i);
    @(posedge clk);
    tgt = -1;
    foreach (mq[i]) if (tgt < 0 && !mq[i].has_data) tgt = i;
    m_byp = 0; m_pop = 0; m_deliv = 0;
    o = '{32'h0, 32'h0, 32'h0};
`ifdef IFETCH_BYPASS_EN
    m_byp = inst_data_ok_i && tgt == 0 && !mq[0].discard && !stall_i && !flush_i;
`endif
    head = (mq.size() > 0) && mq[0].has_data;
    if (m_byp) begin
      m_pop = 1; m_deliv = 1; o = '{mq[0].pc, inst_rdata_i, mq[0].exc};
    end else if (head && (mq[0].discard || flush_i)) begin
      m_pop = 1;
    end else if (head && !stall_i) begin
      m_pop = 1; m_deliv = 1; o = '{mq[0].pc, mq[0].data, mq[0].exc};
    end
    if (inst_data_ok_i && tgt >= 0) begin
      mq[tgt].data = inst_rdata_i;
      mq[tgt].has_data = 1;
    end
    if (flush_i) foreach (mq[i]) mq[i].discard = 1;
    if (m_pop) void'(mq.pop_front());
    if (inst_data_ok_i && bq.size() > 0) void'(bq.pop_front());
    if (m_push) begin
      mq.push_back('{inst_vaddr_i, excepttype_i, 32'h0, excepttype_i != 0, 1'b0});
      if (excepttype_i == 0) bq.push_back('{inst_vaddr_i, cyc});
      pc_cur = inst_vaddr_i + 32'd4;
    end
    if (m_deliv) begin
      sb.push_back(o);
      exp_valid = 1;
    end else if (flush_i || !stall_i) begin
      exp_valid = 0;
    end
    prev_stall = stall_i;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit st, input bit fl, input bit ex, input bit aok, input bit dok);
    stall_i = st;
    flush_i = fl;
    if (fl) pc_cur = 32'hbfc00380;
    excepttype_i   = ex ? 32'h00008000 : 32'h0;
    inst_vaddr_i   = pc_cur;
    inst_addr_ok_i = aok;
    if (dok && bq.size() > 0 && bq[0].cyc < cyc) begin
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = mem_data(bq[0].addr);
    end else begin
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = $urandom;
    end
    cycle();
  endtask

  // Monitor: a fresh payload appears whenever valid is high after an unstalled edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("if_valid", 32'(if_valid_o), 32'(exp_valid));
      if (if_valid_o) begin
        if (!prev_stall) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL deliver (cycle %0d): got pc %08h expected no delivery", cyc, if_pc_o);
          end else begin
            held = sb.pop_front();
          end
        end
        chk("if_pc", if_pc_o, held.pc);
        chk("if_inst", if_inst_o, held.inst);
        chk("if_excepttype", if_excepttype_o, held.exc);
      end
    end
  end

  task automatic reset_model();
    mq.delete(); sb.delete(); bq.delete();
    exp_valid = 0; prev_stall = 0; pc_cur = 32'hbfc00000;
    held = '{32'h0, 32'h0, 32'h0};
  endtask

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    chk("reset if_valid", 32'(if_valid_o), 32'h0);
    chk("reset if_pc", if_pc_o, 32'h0);
    chk("reset if_inst", if_inst_o, 32'h0);
    chk("reset if_excepttype", if_excepttype_o, 32'h0);
    rst = 1'b1;

    // sequential pair 0xbfc00000 / 0xbfc00004
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
    repeat (4) drive(0, 0, 0, 0, 0);
    // full: no data_ok, request must drop
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 1);
    repeat (2) drive(0, 0, 0, 0, 0);
    // stall while data returns
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
    repeat (3) drive(1, 0, 0, 0, 1);
    repeat (4) drive(0, 0, 0, 0, 1);
    // flush with new PC 0xbfc00380 accepted in the flush cycle
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 1, 0);
    repeat (6) drive(0, 0, 0, 0, 1);
    // exception fetch
    drive(0, 0, 1, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // reset mid-fetch with the queue full
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
    rst = 1'b0;
    reset_model();
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; excepttype_i = '0;
    @(negedge clk);
    chk("midreset if_valid", 32'(if_valid_o), 32'h0);
    chk("midreset if_pc", if_pc_o, 32'h0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
    repeat (20) drive(0, 0, 0, 0, 1);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    chk("bus drained", 32'(bq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
